pipe_stage_multi: RTL and testbench

- Parametrised successor of the single-register pipeline stage, for the multi-issue pipeline.
- Carries LANES issue slots of STAGE_WIDTH bits each.
- Uses a valid/ready handshake with a 2-entry skid buffer, so in_ready never depends combinationally on out_ready.
- Supports a global stall and per-lane selective flush (generalises the single issue_select).
- Sits between any two pipeline stages (IF/ID, ID/EX, ...), replacing hand-built stall/flush registers.

---
 rtl/pipe_stage_multi.sv | 106 ++++++++++
 tb/tb_pipe_stage_multi.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_multi.sv
// Multi-lane pipeline register with a 2-entry skid buffer, global stall and per-lane flush; 1-cycle latency, in_ready = ~skid_full & ~stall.
// Define PIPE_STAGE_CLR_DATA_EN to force the data of every non-valid lane to zero.
module pipe_stage_multi #(
  parameter int STAGE_WIDTH = 32,
  parameter int LANES       = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           stall,
  input  logic                           flush,
  input  logic [LANES-1:0]               flush_mask,
  input  logic [LANES-1:0]               in_valid,
  input  logic [LANES*STAGE_WIDTH-1:0]   in_data,
  output logic                           in_ready,
  output logic [LANES-1:0]               out_valid,
  output logic [LANES*STAGE_WIDTH-1:0]   out_data,
  input  logic                           out_ready,
  output logic [1:0]                     occupancy
);

  localparam int DW = LANES * STAGE_WIDTH;

  logic [LANES-1:0] main_vld_q, main_vld_d;
  logic [LANES-1:0] skid_vld_q, skid_vld_d;
  logic [DW-1:0]    main_dat_q, main_dat_d;
  logic [DW-1:0]    skid_dat_q, skid_dat_d;
  logic [1:0]       occ_q, occ_d;
  logic             main_present, skid_present, push, pop;

  always_comb begin
    main_present = |main_vld_q;
    skid_present = |skid_vld_q;
    in_ready     = ~skid_present & ~stall;
    push         = (|in_valid) & in_ready;
    pop          = main_present & out_ready & ~stall;

    main_vld_d = main_vld_q;
    main_dat_d = main_dat_q;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;

    if (!stall) begin
      if (pop) begin
        if (skid_present) begin
          main_vld_d = skid_vld_q;
          main_dat_d = skid_dat_q;
          skid_vld_d = '0;
        end else if (push) begin
          main_vld_d = in_valid;
          main_dat_d = in_data;
        end else begin
          main_vld_d = '0;
        end
      end else if (push) begin
        if (main_present) begin
          skid_vld_d = in_valid;
          skid_dat_d = in_data;
        end else begin
          main_vld_d = in_valid;
          main_dat_d = in_data;
        end
      end

      // Flush acts on the post-movement state so an accepted entry is killed too.
      if (flush) begin
        main_vld_d = main_vld_d & ~flush_mask;
        skid_vld_d = skid_vld_d & ~flush_mask;
        if (!(|main_vld_d) && (|skid_vld_d)) begin
          main_vld_d = skid_vld_d;
          main_dat_d = skid_dat_d;
          skid_vld_d = '0;
        end
      end
    end

`ifdef PIPE_STAGE_CLR_DATA_EN
    for (int i = 0; i < LANES; i++) begin
      if (!main_vld_d[i]) main_dat_d[i*STAGE_WIDTH +: STAGE_WIDTH] = '0;
      if (!skid_vld_d[i]) skid_dat_d[i*STAGE_WIDTH +: STAGE_WIDTH] = '0;
    end
`endif

    occ_d = {1'b0, |main_vld_d} + {1'b0, |skid_vld_d};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_vld_q <= '0;
      main_dat_q <= '0;
      skid_vld_q <= '0;
      skid_dat_q <= '0;
      occ_q      <= '0;
    end else begin
      main_vld_q <= main_vld_d;
      main_dat_q <= main_dat_d;
      skid_vld_q <= skid_vld_d;
      skid_dat_q <= skid_dat_d;
      occ_q      <= occ_d;
    end
  end

  assign out_valid = main_vld_q;
  assign out_data  = main_dat_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_multi.sv
// Scoreboard bench for pipe_stage_multi: a queue model of held entries is checked every cycle.
module tb_pipe_stage_multi;
  localparam int W  = 32;
  localparam int L  = 2;
  localparam int DW = W * L;

  logic          clk = 1'b0;
  logic          rst_n, stall, flush, out_ready, in_ready;
  logic [L-1:0]  flush_mask, in_valid, out_valid;
  logic [DW-1:0] in_data, out_data;
  logic [1:0]    occupancy;

  always #5 clk = ~clk;

  pipe_stage_multi #(.STAGE_WIDTH(W), .LANES(L)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .flush      (flush),
    .flush_mask (flush_mask),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .occupancy  (occupancy)
  );

  typedef struct {
    logic [L-1:0]  vld;
    logic [DW-1:0] dat;
  } ent_t;

  ent_t  sb[$];
  int    n_chk  = 0;
  int    n_fail = 0;
  string phase  = "reset";

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s [%s]: got %h, expected %h", tag, phase, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] lane_bits(input logic [L-1:0] v);
    logic [DW-1:0] m;
    m = '0;
    for (int i = 0; i < L; i++) if (v[i]) m[i*W +: W] = '1;
    return m;
  endfunction

  function automatic ent_t mk(input logic [L-1:0] v, input logic [DW-1:0] d);
    ent_t e;
    e.vld = v;
`ifdef PIPE_STAGE_CLR_DATA_EN
    e.dat = d & lane_bits(v);
`else
    e.dat = d;
`endif
    return e;
  endfunction

  // One clock: drive at negedge, check outputs against the model, then advance the model.
  task automatic step(input logic st, input logic fl, input logic [L-1:0] fm,
                      input logic [L-1:0] iv, input logic [DW-1:0] id, input logic ordy);
    logic          exp_rdy, do_push, do_pop;
    logic [L-1:0]  hv;
    logic [DW-1:0] hd, cmp_m;
    @(negedge clk);
    stall = st; flush = fl; flush_mask = fm;
    in_valid = iv; in_data = id; out_ready = ordy;
    #1;
    exp_rdy = (sb.size() < 2) && !st;
    if (sb.size() > 0) begin
      hv = sb[0].vld;
      hd = sb[0].dat;
    end else begin
      hv = '0;
      hd = '0;
    end
`ifdef PIPE_STAGE_CLR_DATA_EN
    cmp_m = '1;
`else
    cmp_m = lane_bits(hv);
`endif
    chk("in_ready",  DW'(in_ready),  DW'(exp_rdy));
    chk("out_valid", DW'(out_valid), DW'(hv));
    chk("out_data",  out_data & cmp_m, hd & cmp_m);
    chk("occupancy", DW'(occupancy), DW'(sb.size()));
    do_push = (|iv) && exp_rdy;
    do_pop  = (sb.size() > 0) && ordy && !st;
    @(posedge clk);
    if (do_pop)  void'(sb.pop_front());
    if (do_push) sb.push_back(mk(iv, id));
    if (fl && !st) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
        sb[i].vld = sb[i].vld & ~fm;
`ifdef PIPE_STAGE_CLR_DATA_EN
        sb[i].dat = sb[i].dat & lane_bits(sb[i].vld);
`endif
        if (sb[i].vld == '0) sb.delete(i);
      end
    end
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 1'b0, '0, '0, '0, ordy);
  endtask

  task automatic push(input logic [L-1:0] iv, input logic [DW-1:0] id, input logic ordy);
    step(1'b0, 1'b0, '0, iv, id, ordy);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; flush_mask = '0;
    in_valid = 2'b11; in_data = {32'hDEAD_0001, 32'hDEAD_0000}; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_out_valid", DW'(out_valid), '0);
    chk("rst_out_data",  out_data, '0);
    chk("rst_occupancy", DW'(occupancy), '0);
    rst_n = 1'b1; in_valid = '0; in_data = '0;

    phase = "single";
    push(2'b11, {32'hB, 32'hA}, 1'b1);
    idle(1'b1);
    idle(1'b1);

    phase = "backpressure";
    push(2'b11, {32'hE1_01, 32'hE1_00}, 1'b0);
    push(2'b11, {32'hE2_01, 32'hE2_00}, 1'b0);
    push(2'b11, {32'hE3_01, 32'hE3_00}, 1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    phase = "stall";
    push(2'b11, {32'h51, 32'h50}, 1'b0);
    push(2'b11, {32'h61, 32'h60}, 1'b0);
    repeat (3) step(1'b1, 1'b1, 2'b11, 2'b11, {32'h71, 32'h70}, 1'b1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    phase = "partial_flush";
    push(2'b11, {32'h81, 32'h80}, 1'b0);
    step(1'b0, 1'b1, 2'b10, '0, '0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);

    phase = "compaction";
    push(2'b01, {32'h91, 32'h90}, 1'b0);
    push(2'b10, {32'hA1, 32'hA0}, 1'b0);
    step(1'b0, 1'b1, 2'b01, '0, '0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);

    phase = "flush_push";
    step(1'b0, 1'b1, 2'b11, 2'b11, {32'hB1, 32'hB0}, 1'b1);
    step(1'b0, 1'b1, 2'b00, 2'b10, {32'hC1, 32'hC0}, 1'b0);
    idle(1'b1);
    idle(1'b1);

    phase = "throughput";
    for (int i = 0; i < 20; i++) push(2'b11, {32'h100 + i, 32'h200 + i}, 1'b1);
    idle(1'b1);
    idle(1'b1);

    phase = "random";
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0), 2'($urandom),
           2'($urandom), {$urandom, $urandom}, ($urandom_range(0, 3) != 0));
    end
    phase = "drain";
    repeat (4) idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
